// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types for the RAM burst controller: FSM states, read-buffer depth,
// and the read-credit helper used by the issue logic.
package ram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int unsigned SKID_DEPTH = 2;

  // Words that will still be held after this cycle: buffered + arriving - leaving.
  function automatic logic [2:0] rd_credit_used(input logic [1:0] occ,
                                                input logic       inflight,
                                                input logic       pop);
    return {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-stream and read-stream bundle between a DMA engine (master)
// and the burst controller (slave).
interface ram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/ram_rd_skid.sv
// Two-entry read buffer fed by RAM read data; an arriving word flows straight
// to the output when the buffer is empty, otherwise it waits in order for pop.
module ram_rd_skid
  import ram_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop_rdy,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;
  logic                  bypass;
  logic                  fire;
  logic                  store;
  logic                  drain;

  assign bypass  = (cnt == 2'd0) && push_vld;
  assign out_vld = (cnt != 2'd0) || push_vld;
  assign out_dat = bypass ? push_dat : mem[rd_ptr];
  assign fire    = out_vld && pop_rdy;
  // An arriving word consumed on the same cycle never occupies an entry.
  assign store   = push_vld && !(bypass && fire);
  assign drain   = fire && !bypass;
  assign occ     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (drain) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, store} - {1'b0, drain};
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Sequences write/read burst commands onto a 1-cycle-latency single-port RAM.
// Writes: 1 beat/cycle gated by wr_valid; reads: first word accept+2, credit-limited to 2 outstanding.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_burst_ctrl_if.slave       bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_t                state_q;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic                  accept;
  logic                  wr_hs;
  logic                  issue;
  logic                  rd_pop_rdy;
  logic                  rd_pop;
  logic [2:0]            credit;
  logic                  skid_vld;
  logic [DATA_WIDTH-1:0] skid_dat;
  logic [1:0]            skid_occ;

  assign accept     = bus.cmd_valid && (state_q == ST_IDLE);
  assign wr_hs      = (state_q == ST_WRITE) && bus.wr_valid;
  assign rd_pop_rdy = (state_q == ST_READ) && bus.rd_ready;
  assign rd_pop     = skid_vld && rd_pop_rdy;
  assign credit     = rd_credit_used(skid_occ, inflight_q, rd_pop);
  assign issue      = (state_q == ST_READ) && (rem_q != '0) && (credit < 3'(SKID_DEPTH));

  ram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_rd_skid (
    .clk      (clk),
    .rst      (rst),
    .push_vld (inflight_q),
    .push_dat (ram_dout),
    .pop_rdy  (rd_pop_rdy),
    .out_vld  (skid_vld),
    .out_dat  (skid_dat),
    .occ      (skid_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_q;
    ram_din      = bus.wr_data;
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.wr_ready  = (state_q == ST_WRITE);
    bus.rd_valid  = skid_vld && (state_q == ST_READ);
    bus.rd_data   = skid_dat;
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_FIN);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.cmd_len == '0)  state_nxt = ST_FIN;
          else if (bus.cmd_write) state_nxt = ST_WRITE;
          else                    state_nxt = ST_READ;
        end
      end
      ST_WRITE: begin
        ram_en = wr_hs && !rst;
        ram_we = wr_hs && !rst;
        if (wr_hs && rem_q == LEN_WIDTH'(1)) state_nxt = ST_FIN;
      end
      ST_READ: begin
        ram_en = issue && !rst;
        // Finish once the final word has left and nothing is buffered or in flight.
        if (rd_pop && rem_q == '0 && credit == 3'd0) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q <= bus.cmd_addr;
        rem_q  <= bus.cmd_len;
      end else if (wr_hs || issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: directed and random bursts checked against a shadow
// memory, expected-word queues and cycle-count rules for latency and done.
module tb_ram_burst_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LW    = 5;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] ram     [DEPTH] = '{default: '0};
  logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
  bit            pat     [6]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  ram_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      else        ram_dout      <= ram[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cmd_accept(input bit wr, input logic [AW-1:0] a, input int n, output int acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = LW'(n);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h5A;
    bus.rd_ready  = 1'b1;
    @(negedge clk);
    chk("acc_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("acc_ram_en", 32'(ram_en), 0);
    chk("acc_wr_ready", 32'(bus.wr_ready), 0);
    chk("acc_rd_valid", 32'(bus.rd_valid), 0);
    acc = cyc;
  endtask

  task automatic finish_burst();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    @(negedge clk);
    chk("fin_done", 32'(bus.done), 1);
    chk("fin_busy", 32'(bus.busy), 1);
    chk("fin_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("fin_ram_en", 32'(ram_en), 0);
    chk("fin_rd_valid", 32'(bus.rd_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_done", 32'(bus.done), 0);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_cmd_ready", 32'(bus.cmd_ready), 1);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int n, input bit rnd, input logic [DW-1:0] base);
    int acc;
    int i;
    int k;
    logic [DW-1:0] d;
    logic [AW-1:0] wa;
    cmd_accept(1'b1, a, n, acc);
    i = 0;
    k = 0;
    while (i < n && k < 400) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      d = rnd ? DW'($urandom) : base + DW'(i);
      bus.wr_data  = d;
      bus.wr_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      chk("wr_ready", 32'(bus.wr_ready), 1);
      chk("wr_busy", 32'(bus.busy), 1);
      chk("wr_done_early", 32'(bus.done), 0);
      chk("wr_rd_valid", 32'(bus.rd_valid), 0);
      if (bus.wr_valid) begin
        wa = a + AW'(i);
        chk("wr_en", 32'(ram_en), 1);
        chk("wr_we", 32'(ram_we), 1);
        chk("wr_addr", 32'(ram_addr), 32'(wa));
        chk("wr_din", 32'(ram_din), 32'(d));
        ref_mem[wa] = d;
        i++;
      end else begin
        chk("wr_idle_en", 32'(ram_en), 0);
      end
      k++;
    end
    chk("wr_beats", i, n);
    finish_burst();
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int n, input int mode, input int abort_at);
    int acc;
    int issued;
    int popped;
    int k;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] ea;
    for (int j = 0; j < n; j++) begin
      ea = a + AW'(j);
      exp_q.push_back(ref_mem[ea]);
    end
    cmd_accept(1'b0, a, n, acc);
    issued = 0;
    popped = 0;
    k = 0;
    while (popped < n && k < 400) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (mode == 0)      bus.rd_ready = 1'b1;
      else if (mode == 1) bus.rd_ready = pat[k % 6];
      else                bus.rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rd_credit", 32'((issued - popped) <= 2), 1);
      chk("rd_busy", 32'(bus.busy), 1);
      chk("rd_done_early", 32'(bus.done), 0);
      chk("rd_wr_ready", 32'(bus.wr_ready), 0);
      if (ram_en) begin
        ea = a + AW'(issued);
        chk("rd_we", 32'(ram_we), 0);
        chk("rd_extra_issue", 32'(issued < n), 1);
        chk("rd_addr", 32'(ram_addr), 32'(ea));
        issued++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("rd_data", 32'(bus.rd_data), 32'(exp_q[popped]));
        if (mode == 0) chk("rd_latency", cyc, acc + 2 + popped);
        popped++;
        if (abort_at > 0 && popped == abort_at) break;
      end
      k++;
    end
    if (abort_at > 0) begin
      chk("abort_popped", popped, abort_at);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rd_valid", 32'(bus.rd_valid), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("abort_done", 32'(bus.done), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0);
      chk("abort_ram_en", 32'(ram_en), 0);
    end else begin
      chk("rd_words", popped, n);
      chk("rd_issued", issued, n);
      finish_burst();
    end
  endtask

  task automatic noop(input bit wr, input logic [AW-1:0] a);
    int acc;
    cmd_accept(wr, a, 0, acc);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("noop_done", 32'(bus.done), 1);
    chk("noop_ram_en", 32'(ram_en), 0);
    chk("noop_busy", 32'(bus.busy), 1);
    chk("noop_cmd_ready", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("noop_post_done", 32'(bus.done), 0);
    chk("noop_post_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("noop_post_ram_en", 32'(ram_en), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ram_en", 32'(ram_en), 0);
    chk("reset_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset_wr_ready", 32'(bus.wr_ready), 0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 0);
    chk("reset_rd_data", 32'(bus.rd_data), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);

    wr_burst(4'd2, 4, 1'b0, 8'hA0);
    for (int j = 0; j < 4; j++) chk("ram_after_write", 32'(ram[2 + j]), 32'(8'hA0 + j));
    rd_burst(4'd2, 4, 0, 0);
    rd_burst(4'd0, 8, 1, 0);
    wr_burst(4'd14, 4, 1'b0, 8'hB0);
    rd_burst(4'd14, 4, 0, 0);
    noop(1'b1, 4'd7);
    noop(1'b0, 4'd3);
    rd_burst(4'd1, 6, 0, 2);
    rd_burst(4'd1, 6, 0, 0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) wr_burst(AW'($urandom), $urandom_range(1, 16), 1'b1, 8'h00);
      else                           rd_burst(AW'($urandom), $urandom_range(1, 16), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
